// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle controller: FSM states,
// supported opcodes, ALU operation encodings and instruction classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    CLS_RTYPE  = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Maps a 7-bit opcode to its instruction class and flags whether the
// controller supports it at all.
module op_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       legal
);

  // Pure lookup; unsupported opcodes report legal=0 and a don't-care class
  always_comb begin
    op_class = CLS_RTYPE;
    legal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin op_class = CLS_RTYPE;  legal = 1'b1; end
      OP_LW:    begin op_class = CLS_LOAD;   legal = 1'b1; end
      OP_SW:    begin op_class = CLS_STORE;  legal = 1'b1; end
      OP_BEQ:   begin op_class = CLS_BRANCH; legal = 1'b1; end
      default:  begin op_class = CLS_RTYPE;  legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// a memory wait-timeout counter and a retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_err,
  output logic [31:0] instret
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       instret_q, instret_d;

  logic      done_raw, illegal_raw, err_raw;
  logic      at_limit;
  op_class_t cls;
  logic      cls_legal;
  logic      unused_zero;

  // The branch decision on zero is taken by the datapath's PC write enable,
  // so the controller deliberately ignores the flag.
  assign unused_zero = zero;

  // In DECODE the live opcode is classified; afterwards the latched copy is.
  op_class_decode u_op_class_decode (
    .opcode   ((state_q == DECODE) ? opcode : op_q),
    .op_class (cls),
    .legal    (cls_legal)
  );

  assign at_limit = (wait_q == WAIT_MAX);

  // Status pulses are suppressed while reset is held so an access that
  // completes under reset never counts as a retirement.
  assign instr_done = done_raw    & ~reset;
  assign illegal    = illegal_raw & ~reset;
  assign mem_err    = err_raw     & ~reset;
  assign state      = state_q;
  assign instret    = instret_q;

  // Next-state logic plus control outputs decoded from the current state
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = '0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrc      = 1'b0;
    Branch      = 1'b0;
    ALUOp       = ALU_ADD;
    done_raw    = 1'b0;
    illegal_raw = 1'b0;
    err_raw     = 1'b0;

    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else if (at_limit) begin
          err_raw = 1'b1;
          state_d = FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DECODE: begin
        op_d = opcode;
        if (cls_legal) begin
          state_d = EXECUTE;
        end else begin
          illegal_raw = 1'b1;
          state_d     = FETCH;
        end
      end
      EXECUTE: begin
        case (cls)
          CLS_RTYPE: begin
            ALUOp   = ALU_FUNCT;
            state_d = WRITEBACK;
          end
          CLS_LOAD, CLS_STORE: begin
            ALUSrc  = 1'b1;
            ALUOp   = ALU_ADD;
            state_d = MEMORY;
          end
          default: begin
            Branch      = 1'b1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            done_raw    = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEMORY: begin
        IorD = 1'b1;
        if (cls == CLS_LOAD) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = mem_ready | ~at_limit;
        end
        if (mem_ready) begin
          if (cls == CLS_LOAD) begin
            state_d = WRITEBACK;
          end else begin
            done_raw = 1'b1;
            state_d  = FETCH;
          end
        end else if (at_limit) begin
          err_raw = 1'b1;
          state_d = FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WRITEBACK: begin
        RegWrite = 1'b1;
        MemtoReg = (op_q == OP_LW);
        done_raw = 1'b1;
        state_d  = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    instret_d = instret_q + (instr_done ? 32'd1 : 32'd0);
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams compared against an instruction-level model.
module tb_multicycle_controller;

  localparam int TO = 15;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BQ  = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite;
  logic        RegWrite, MemtoReg, ALUSrc, Branch;
  logic [1:0]  ALUOp;
  logic [2:0]  state;
  logic        instr_done, illegal, mem_err;
  logic [31:0] instret;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, pcwc, irw, iord, mrd, mwr, rwr, m2r, asrc, br;
    logic [1:0] aluop;
    logic done, ill, err;
  } ctl_t;

  int checks  = 0;
  int errors  = 0;
  int retired = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IRWrite     (IRWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrc      (ALUSrc),
    .Branch      (Branch),
    .ALUOp       (ALUOp),
    .state       (state),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .mem_err     (mem_err),
    .instret     (instret)
  );

  function automatic ctl_t idle(input logic [2:0] st);
    ctl_t c;
    c    = '0;
    c.st = st;
    return c;
  endfunction

  function automatic logic [6:0] rnd7();
    return 7'($urandom_range(0, 127));
  endfunction

  // Drive one cycle's inputs at the falling edge and let them settle
  task automatic applyStimulus(input logic rst, input logic [6:0] op, input logic rdy);
    @(negedge clk);
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    zero      = 1'($urandom_range(0, 1));
    #1;
  endtask

  // Compare all outputs of this cycle, and the retire count so far
  task automatic checkOutput(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = {state, PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite,
           RegWrite, MemtoReg, ALUSrc, Branch, ALUOp, instr_done, illegal, mem_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s ctl observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (instret === 32'(retired)) else begin
      errors++;
      $error("[TB] FAIL %s instret observed=%0d expected=%0d", tag, instret, retired);
    end
    if (exp.done) retired++;
  endtask

  // Instruction-level model: walks one instruction through its phases.
  // fw/mw are the number of not-ready cycles before memory answers; a value
  // above TO means the access times out.
  task automatic runInstr(input string name, input logic [6:0] op, input int fw, input int mw);
    ctl_t e;
    logic rdy;
    logic legal;
    legal = (op == RT) || (op == LD) || (op == ST) || (op == BQ);
    for (int k = 0; k <= TO; k++) begin
      rdy   = (k == fw);
      e     = idle(3'd0);
      e.mrd = 1'b1;
      if (rdy) begin
        e.irw = 1'b1;
        e.pcw = 1'b1;
      end else if (k == TO) begin
        e.err = 1'b1;
      end
      applyStimulus(1'b0, rnd7(), rdy);
      checkOutput({name, "/fetch"}, e);
      if (rdy) break;
      if (k == TO) return;
    end
    e     = idle(3'd1);
    e.ill = !legal;
    applyStimulus(1'b0, op, 1'($urandom_range(0, 1)));
    checkOutput({name, "/decode"}, e);
    if (!legal) return;
    e = idle(3'd2);
    if (op == RT) e.aluop = 2'b10;
    if (op == LD || op == ST) e.asrc = 1'b1;
    if (op == BQ) begin
      e.br    = 1'b1;
      e.pcwc  = 1'b1;
      e.aluop = 2'b01;
      e.done  = 1'b1;
    end
    applyStimulus(1'b0, rnd7(), 1'($urandom_range(0, 1)));
    checkOutput({name, "/execute"}, e);
    if (op == BQ) return;
    if (op != RT) begin
      for (int k = 0; k <= TO; k++) begin
        rdy    = (k == mw);
        e      = idle(3'd3);
        e.iord = 1'b1;
        if (op == LD) e.mrd = 1'b1;
        if (op == ST) begin
          e.mwr  = rdy || (k != TO);
          e.done = rdy;
        end
        if (!rdy && k == TO) e.err = 1'b1;
        applyStimulus(1'b0, rnd7(), rdy);
        checkOutput({name, "/memory"}, e);
        if (e.done || e.err) return;
        if (rdy) break;
      end
    end
    e      = idle(3'd4);
    e.rwr  = 1'b1;
    e.m2r  = (op == LD);
    e.done = 1'b1;
    applyStimulus(1'b0, rnd7(), 1'($urandom_range(0, 1)));
    checkOutput({name, "/writeback"}, e);
  endtask

  initial begin
    ctl_t e;
    int   sel, fw, mw;
    logic [6:0] op;

    reset     = 1'b1;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);

    // Reset state: FETCH with MemRead while reset is held
    e     = idle(3'd0);
    e.mrd = 1'b1;
    applyStimulus(1'b1, 7'd0, 1'b0);
    checkOutput("reset0", e);
    applyStimulus(1'b1, 7'd0, 1'b0);
    checkOutput("reset1", e);

    // Reset during the ready cycle of a store: no retirement, back to FETCH
    e = idle(3'd0); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    applyStimulus(1'b0, rnd7(), 1'b1);
    checkOutput("swrst/fetch", e);
    applyStimulus(1'b0, ST, 1'b0);
    checkOutput("swrst/decode", idle(3'd1));
    e = idle(3'd2); e.asrc = 1'b1;
    applyStimulus(1'b0, rnd7(), 1'b0);
    checkOutput("swrst/execute", e);
    e = idle(3'd3); e.iord = 1'b1; e.mwr = 1'b1;
    applyStimulus(1'b0, rnd7(), 1'b0);
    checkOutput("swrst/mem0", e);
    applyStimulus(1'b1, rnd7(), 1'b1);
    checkOutput("swrst/mem_rst", e);
    e = idle(3'd0); e.mrd = 1'b1;
    applyStimulus(1'b1, rnd7(), 1'b0);
    checkOutput("swrst/after", e);

    // Directed instruction scenarios
    runInstr("rtype",      RT, 0, 0);
    runInstr("lw_wait3",   LD, 0, 3);
    runInstr("beq",        BQ, 0, 0);
    runInstr("beq2",       BQ, 0, 0);
    runInstr("sw",         ST, 0, 0);
    runInstr("lw",         LD, 0, 0);
    runInstr("illegal",    7'b0010011, 0, 0);
    runInstr("fetch_to",   RT, TO + 1, 0);
    runInstr("fetch_edge", RT, TO, 0);
    runInstr("sw_to",      ST, 1, TO + 1);
    runInstr("lw_to",      LD, 0, TO + 1);
    runInstr("lw_edge",    LD, 2, TO);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       op = RT;
        1:       op = LD;
        2:       op = ST;
        3:       op = BQ;
        default: op = rnd7();
      endcase
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
      runInstr("random", op, fw, mw);
    end

    // Final retire count after the last instruction's edge
    e = idle(3'd0); e.mrd = 1'b1;
    applyStimulus(1'b0, rnd7(), 1'b0);
    checkOutput("final", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
